// File: rtl/div16_rebuild_if.sv
// Handshake and operand bundle shared between a producer (e.g. div16 or a
// sequencer) and the div16_rebuild multiply-add unit.
interface div16_rebuild_if #(
    parameter int W = 16
);
    logic             nd;
    logic [W-1:0]     quotient;
    logic [W-1:0]     divisor;
    logic [W-1:0]     remainder;
    logic             rfd;
    logic             rdy;
    logic [2*W-1:0]   product;
    logic             err;

    modport master (
        output nd, quotient, divisor, remainder,
        input  rfd, rdy, product, err
    );

    modport slave (
        input  nd, quotient, divisor, remainder,
        output rfd, rdy, product, err
    );
endinterface

// File: rtl/div16_rebuild.sv
// Rebuilds a divider dividend as quotient * divisor + remainder using a
// shift-add multiplier, one partial product per clock. Also flags tuples
// that a divider could never have produced (divisor 0 or remainder too big).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | rfd high, waiting for nd; operands captured on the load edge
// RUN   | one partial product per clock, W clocks in total
// DONE  | rdy high for one cycle, product/err already valid
module div16_rebuild #(
    parameter int W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    div16_rebuild_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   md;
    logic [W-1:0]     mq;
    logic [CW-1:0]    cnt;
    logic             err_r;
    logic [2*W-1:0]   product_q;
    logic             err_q;

    logic             load;
    logic             last_iter;
    logic [2*W-1:0]   acc_sum;
    logic             tuple_bad;

    // nd only counts while we are ready; anything else is silently dropped
    assign load      = (state == IDLE) && bus.nd;
    assign last_iter = (state == RUN) && (cnt == CW'(W - 1));

    // A legal divider result always has 0 <= remainder < divisor
    assign tuple_bad = (bus.divisor == '0) || (bus.remainder >= bus.divisor);

    // Conditional add of the shifted multiplicand; cannot overflow 2W bits
    always_comb begin
        acc_sum = acc;
        if (mq[0]) begin
            acc_sum = acc + md;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.nd) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded straight from the state flops
    always_comb begin
        bus.rfd = 1'b0;
        bus.rdy = 1'b0;
        case (state)
            IDLE:    bus.rfd = 1'b1;
            DONE:    bus.rdy = 1'b1;
            default: begin
                bus.rfd = 1'b0;
                bus.rdy = 1'b0;
            end
        endcase
    end

    // Working registers: captured on load, stepped once per RUN clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            md    <= '0;
            mq    <= '0;
            cnt   <= '0;
            err_r <= 1'b0;
        end else if (load) begin
            acc   <= {{W{1'b0}}, bus.remainder};
            md    <= {{W{1'b0}}, bus.divisor};
            mq    <= bus.quotient;
            cnt   <= '0;
            err_r <= tuple_bad;
        end else if (state == RUN) begin
            acc   <= acc_sum;
            md    <= md << 1;
            mq    <= mq >> 1;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers load together with the final partial product so they
    // are valid the same cycle rdy rises, and hold until the next result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q <= '0;
            err_q     <= 1'b0;
        end else if (last_iter) begin
            product_q <= acc_sum;
            err_q     <= err_r;
        end
    end

    assign bus.product = product_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_div16_rebuild.sv
// Directed and randomised-legal-tuple bench for div16_rebuild.
module tb_div16_rebuild;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   overlap;

    div16_rebuild_if #(.W(16)) bus ();

    div16_rebuild #(.W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rfd and rdy must never be seen together
    always @(negedge clk) begin
        if (rst_n && bus.rfd && bus.rdy) overlap++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] q, input logic [15:0] d, input logic [15:0] r);
        bus.quotient  = q;
        bus.divisor   = d;
        bus.remainder = r;
    endtask

    // One operation: lat = negedges after load edge where rdy first seen
    task automatic run_op(input logic [15:0] q, input logic [15:0] d, input logic [15:0] r,
                          output logic [31:0] p, output logic e,
                          output int lat, output int rfd_low);
        int waitc;
        waitc = 0;
        @(negedge clk);
        while (!bus.rfd && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        drive(q, d, r);
        bus.nd = 1'b1;
        @(posedge clk);
        #1 bus.nd = 1'b0;
        lat = -1;
        rfd_low = 0;
        p = '0;
        e = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (!bus.rfd) rfd_low++;
            if (bus.rdy && lat < 0) begin
                lat = k;
                p = bus.product;
                e = bus.err;
            end
            if (lat > 0 && bus.rfd) break;
        end
    endtask

    initial begin
        logic [31:0] p;
        logic        e;
        int          lat;
        int          rl;
        int          rdy_cnt;
        int          cyc;
        int          prev;
        int          done;
        int          timer;
        logic [15:0] q;
        logic [15:0] d;
        logic [15:0] r;
        logic [31:0] expv;
        logic [15:0] x;

        n_checks = 0;
        n_pass   = 0;
        overlap  = 0;
        rst_n    = 1'b0;
        bus.nd   = 1'b0;
        drive(16'd0, 16'd0, 16'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rfd", 64'(bus.rfd), 64'd1);
        check("rst_rdy", 64'(bus.rdy), 64'd0);
        check("rst_product", 64'(bus.product), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic
        run_op(16'd100, 16'd7, 16'd3, p, e, lat, rl);
        check("basic_latency", 64'(lat), 64'd17);
        check("basic_rfd_low", 64'(rl), 64'd17);
        check("basic_product", 64'(p), 64'd703);
        check("basic_err", 64'(e), 64'd0);
        check("basic_rdy_after", 64'(bus.rdy), 64'd0);

        // Max operands
        run_op(16'hFFFF, 16'hFFFF, 16'hFFFE, p, e, lat, rl);
        check("max_product", 64'(p), 64'hFFFE_FFFF);
        check("max_err", 64'(e), 64'd0);

        // Error tuples
        run_op(16'd5, 16'd0, 16'd9, p, e, lat, rl);
        check("err_d0_product", 64'(p), 64'd9);
        check("err_d0_err", 64'(e), 64'd1);
        run_op(16'd2, 16'd10, 16'd10, p, e, lat, rl);
        check("err_req_product", 64'(p), 64'd30);
        check("err_req_err", 64'(e), 64'd1);
        repeat (5) @(negedge clk);
        check("hold_product", 64'(bus.product), 64'd30);
        check("hold_err", 64'(bus.err), 64'd1);

        // Busy rejection: nd and operands wiggle during RUN
        @(negedge clk);
        drive(16'd3, 16'd4, 16'd1);
        bus.nd = 1'b1;
        @(posedge clk);
        #1 bus.nd = 1'b0;
        rdy_cnt = 0;
        p = '0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k >= 4 && k <= 12) begin
                bus.nd = k[0];
                drive(16'(k * 911), 16'(k * 37 + 1), 16'(k));
            end else begin
                bus.nd = 1'b0;
            end
            if (bus.rdy) begin
                rdy_cnt++;
                p = bus.product;
            end
        end
        check("busy_rdy_count", 64'(rdy_cnt), 64'd1);
        check("busy_product", 64'(p), 64'd13);

        // Reset mid-run, at iteration 8
        @(negedge clk);
        drive(16'h1234, 16'h00FF, 16'h0000);
        bus.nd = 1'b1;
        @(posedge clk);
        #1 bus.nd = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rfd", 64'(bus.rfd), 64'd1);
        check("midrst_rdy", 64'(bus.rdy), 64'd0);
        check("midrst_product", 64'(bus.product), 64'd0);
        check("midrst_err", 64'(bus.err), 64'd0);
        rdy_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.rdy) rdy_cnt++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.rdy) rdy_cnt++;
        end
        check("midrst_no_rdy", 64'(rdy_cnt), 64'd0);
        run_op(16'h1234, 16'h00FF, 16'h0000, p, e, lat, rl);
        check("midrst_reload_product", 64'(p), 64'h0012_21CC);
        check("midrst_reload_latency", 64'(lat), 64'd17);

        // Back-to-back with nd held high over random legal tuples
        q = 16'($urandom);
        d = 16'($urandom_range(65535, 1));
        r = 16'($urandom % 32'(d));
        expv = 32'(q) * 32'(d) + 32'(r);
        @(negedge clk);
        drive(q, d, r);
        bus.nd = 1'b1;
        cyc = 0;
        prev = -1;
        done = 0;
        timer = 0;
        while (done < 1000 && timer < 1000 * 18 + 100) begin
            @(negedge clk);
            cyc++;
            timer++;
            if (bus.rdy) begin
                check("b2b_product", 64'(bus.product), 64'(expv));
                check("b2b_err", 64'(bus.err), 64'd0);
                if (prev >= 0) check("b2b_gap", 64'(cyc - prev), 64'd18);
                prev = cyc;
                done++;
                q = 16'($urandom);
                d = 16'($urandom_range(65535, 1));
                r = 16'($urandom % 32'(d));
                expv = 32'(q) * 32'(d) + 32'(r);
                drive(q, d, r);
                if (done == 1000) bus.nd = 1'b0;
            end
        end
        bus.nd = 1'b0;
        check("b2b_count", 64'(done), 64'd1000);

        // Divider-chained tuples: split a dividend, rebuild it
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin x = 16'hBEEF; d = 16'h0037; end
                1:       begin x = 16'hFFFF; d = 16'h0001; end
                default: begin x = 16'h0005; d = 16'h1000; end
            endcase
            q = x / d;
            r = x % d;
            run_op(q, d, r, p, e, lat, rl);
            check("chain_product", 64'(p), 64'(x));
            check("chain_err", 64'(e), 64'd0);
        end

        check("rfd_rdy_overlap", 64'(overlap), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
